pipeline_hazard_ctrl: RTL and testbench

Central sequencing block for the 3-stage pipeline (IF → EX → MEM/WB). Generates the pipeline stall, the branch flush and the EX-stage forwarding selects, and gates register-file writeback. It owns the data-memory request/acknowledge handshake so that load/store can take a variable number of cycles. It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/pipeline_hazard_ctrl_if.sv | 50 +++++
 rtl/pipeline_hazard_ctrl.sv | 141 ++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller interface: EX/MEM stage status in, pipeline control,
// data-memory handshake and performance counters out.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  // EX stage
  logic             ex_valid;
  logic [4:0]       ex_rs1;
  logic [4:0]       ex_rs2;
  logic             ex_use_rs1;
  logic             ex_use_rs2;
  logic             ex_br_taken;
  // MEM stage
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic             mem_reg_wr;
  logic             mem_is_ld;
  logic             mem_is_st;
  // data memory handshake
  logic             dmem_ack;
  logic             dmem_req;
  // pipeline control
  logic             stall;
  logic             flush;
  logic             forward_sel_A;
  logic             forward_sel_B;
  logic             wb_en;
  logic             mem_err;
  // performance counters
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  // Pipeline side: drives stage status and the memory acknowledge
  modport master (
    output ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2, ex_br_taken,
    output mem_valid, mem_rd, mem_reg_wr, mem_is_ld, mem_is_st,
    output dmem_ack,
    input  dmem_req, stall, flush, forward_sel_A, forward_sel_B, wb_en,
    input  mem_err, stall_cnt, flush_cnt
  );

  // Controller side
  modport slave (
    input  ex_valid, ex_rs1, ex_rs2, ex_use_rs1, ex_use_rs2, ex_br_taken,
    input  mem_valid, mem_rd, mem_reg_wr, mem_is_ld, mem_is_st,
    input  dmem_ack,
    output dmem_req, stall, flush, forward_sel_A, forward_sel_B, wb_en,
    output mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 3-stage pipeline: memory-wait stall FSM with
// timeout, branch flush sequencing, EX forwarding selects, writeback gating
// and saturating stall/flush event counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned BR_PENALTY = 1,
  parameter int unsigned MAX_WAIT   = 64,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  pipeline_hazard_ctrl_if.slave bus
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);
  localparam int unsigned REM_W  = (BR_PENALTY > 1) ? $clog2(BR_PENALTY) : 1;

  typedef enum logic {
    ST_RUN,
    ST_MEM_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic [REM_W-1:0]  r_flush_rem;
  logic [REM_W-1:0]  w_flush_rem_nxt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic [CNT_W-1:0]  r_flush_cnt;
  logic              r_mem_err;

  logic              w_mem_op;
  logic              w_wr_ok;
  logic              w_req;
  logic              w_stall;
  logic              w_timeout;
  logic              w_br_new;
  logic              w_flush;

  // Combinational outputs are qualified with reset so that every output
  // reads zero while reset is held, not only the registered ones.
  assign w_mem_op = reset & bus.mem_valid & (bus.mem_is_ld | bus.mem_is_st);
  assign w_wr_ok  = reset & bus.mem_valid & bus.mem_reg_wr & (bus.mem_rd != 5'd0);

  // FSM next state, memory request, stall and timeout detection
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_req          = 1'b0;
    w_stall        = 1'b0;
    w_timeout      = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_req = w_mem_op;
        if (w_mem_op && !bus.dmem_ack) begin
          w_stall        = 1'b1;
          w_state_nxt    = ST_MEM_WAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        w_req = 1'b1;
        if (bus.dmem_ack) begin
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
          w_timeout      = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else begin
          w_stall        = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
    endcase
    if (!reset) begin
      w_req     = 1'b0;
      w_stall   = 1'b0;
      w_timeout = 1'b0;
    end
  end

  // Branch flush: a new taken branch is accepted only when unstalled and no
  // flush sequence is in progress; the remaining count freezes while stalled.
  always_comb begin
    w_br_new        = reset & bus.ex_valid & bus.ex_br_taken & !w_stall &
                      (r_flush_rem == '0);
    w_flush         = w_br_new | (reset & (r_flush_rem != '0));
    w_flush_rem_nxt = r_flush_rem;
    if (w_br_new) begin
      w_flush_rem_nxt = REM_W'(BR_PENALTY - 1);
    end else if ((r_flush_rem != '0) && !w_stall) begin
      w_flush_rem_nxt = r_flush_rem - REM_W'(1);
    end
  end

  // FSM, wait counter and flush sequence registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_flush_rem <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_wait_cnt  <= w_wait_cnt_nxt;
      r_flush_rem <= w_flush_rem_nxt;
    end
  end

  // Sticky timeout flag and saturating event counters
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_timeout) begin
        r_mem_err <= 1'b1;
      end
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
      if (w_flush && (r_flush_cnt != '1)) begin
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.dmem_req      = w_req;
  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.wb_en         = w_wr_ok & !w_stall & !w_timeout;
  assign bus.forward_sel_A = w_wr_ok & bus.ex_valid & bus.ex_use_rs1 &
                             (bus.mem_rd == bus.ex_rs1);
  assign bus.forward_sel_B = w_wr_ok & bus.ex_valid & bus.ex_use_rs2 &
                             (bus.mem_rd == bus.ex_rs2);
  assign bus.mem_err       = r_mem_err;
  assign bus.stall_cnt     = r_stall_cnt;
  assign bus.flush_cnt     = r_flush_cnt;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the control rules.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned BR_PENALTY = 2;
  localparam int unsigned MAX_WAIT   = 4;
  localparam int unsigned CNT_W      = 4;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;

  logic clk;
  logic reset;
  logic chk_en;

  int vectors;
  int miscompares;

  pipeline_hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  pipeline_hazard_ctrl #(
    .BR_PENALTY(BR_PENALTY),
    .MAX_WAIT  (MAX_WAIT),
    .CNT_W     (CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_pend: consecutive cycles the current access has been left unacknowledged
  // m_owed: flush cycles still owed after the current branch's first cycle
  int m_pend, m_owed, m_scnt, m_fcnt;
  bit m_err;

  initial begin
    m_pend = 0; m_owed = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
  end

  always @(negedge clk) begin : model_cmp
    bit mop, wr_ok, e_req, e_stall, e_tmo, e_flush, e_trig, e_fa, e_fb, e_wb;
    if (chk_en) begin
      if (!reset) begin
        {e_req, e_stall, e_flush, e_fa, e_fb, e_wb} = '0;
      end else begin
        mop   = bus.mem_valid & (bus.mem_is_ld | bus.mem_is_st);
        wr_ok = bus.mem_valid & bus.mem_reg_wr & (bus.mem_rd != 0);
        e_tmo = 1'b0;
        if (m_pend == 0) begin
          e_req   = mop;
          e_stall = mop & !bus.dmem_ack;
        end else begin
          e_req = 1'b1;
          if (bus.dmem_ack)            e_stall = 1'b0;
          else if (m_pend == MAX_WAIT) begin e_stall = 1'b0; e_tmo = 1'b1; end
          else                         e_stall = 1'b1;
        end
        e_wb    = wr_ok & !e_stall & !e_tmo;
        e_fa    = wr_ok & bus.ex_valid & bus.ex_use_rs1 & (bus.mem_rd == bus.ex_rs1);
        e_fb    = wr_ok & bus.ex_valid & bus.ex_use_rs2 & (bus.mem_rd == bus.ex_rs2);
        e_trig  = bus.ex_valid & bus.ex_br_taken & !e_stall & (m_owed == 0);
        e_flush = e_trig | (m_owed != 0);
      end
      cmp("m.dmem_req",  32'(bus.dmem_req),      32'(e_req));
      cmp("m.stall",     32'(bus.stall),         32'(e_stall));
      cmp("m.flush",     32'(bus.flush),         32'(e_flush));
      cmp("m.fwdA",      32'(bus.forward_sel_A), 32'(e_fa));
      cmp("m.fwdB",      32'(bus.forward_sel_B), 32'(e_fb));
      cmp("m.wb_en",     32'(bus.wb_en),         32'(e_wb));
      cmp("m.mem_err",   32'(bus.mem_err),       32'(reset ? m_err : 1'b0));
      cmp("m.stall_cnt", 32'(bus.stall_cnt),     32'(reset ? m_scnt : 0));
      cmp("m.flush_cnt", 32'(bus.flush_cnt),     32'(reset ? m_fcnt : 0));
      // advance model to the state seen after the next rising edge
      if (!reset) begin
        m_pend = 0; m_owed = 0; m_scnt = 0; m_fcnt = 0; m_err = 0;
      end else begin
        m_pend = e_stall ? m_pend + 1 : 0;
        if (e_trig) m_owed = BR_PENALTY - 1;
        else if (m_owed != 0 && !e_stall) m_owed = m_owed - 1;
        if (e_tmo) m_err = 1'b1;
        if (e_stall && m_scnt < CNT_MAX) m_scnt++;
        if (e_flush && m_fcnt < CNT_MAX) m_fcnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive_mem(input bit v, input bit ld, input bit st,
                           input logic [4:0] rd, input bit wr, input bit ack);
    bus.mem_valid  = v;
    bus.mem_is_ld  = ld;
    bus.mem_is_st  = st;
    bus.mem_rd     = rd;
    bus.mem_reg_wr = wr;
    bus.dmem_ack   = ack;
  endtask

  task automatic drive_ex(input bit v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input bit u1, input bit u2, input bit br);
    bus.ex_valid    = v;
    bus.ex_rs1      = rs1;
    bus.ex_rs2      = rs2;
    bus.ex_use_rs1  = u1;
    bus.ex_use_rs2  = u2;
    bus.ex_br_taken = br;
  endtask

  task automatic idle();
    drive_mem(0, 0, 0, 5'd0, 0, 0);
    drive_ex(0, 5'd0, 5'd0, 0, 0, 0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic all_zero(input string tag);
    cmp({tag, ".dmem_req"},  32'(bus.dmem_req),      32'd0);
    cmp({tag, ".stall"},     32'(bus.stall),         32'd0);
    cmp({tag, ".flush"},     32'(bus.flush),         32'd0);
    cmp({tag, ".fwdA"},      32'(bus.forward_sel_A), 32'd0);
    cmp({tag, ".fwdB"},      32'(bus.forward_sel_B), 32'd0);
    cmp({tag, ".wb_en"},     32'(bus.wb_en),         32'd0);
    cmp({tag, ".mem_err"},   32'(bus.mem_err),       32'd0);
    cmp({tag, ".stall_cnt"}, 32'(bus.stall_cnt),     32'd0);
    cmp({tag, ".flush_cnt"}, 32'(bus.flush_cnt),     32'd0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    chk_en      = 1'b0;
    reset       = 1'b1;
    idle();
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;

    // reset holds every output low even with a forwarding load presented
    drive_mem(1, 1, 0, 5'd7, 1, 0);
    drive_ex(1, 5'd7, 5'd7, 1, 1, 1);
    @(negedge clk); all_zero("rst");
    step(); reset = 1'b1; idle();

    // zero-wait load
    step(); drive_mem(1, 1, 0, 5'd5, 1, 1);
    @(negedge clk);
    cmp("zw.req",   32'(bus.dmem_req), 32'd1);
    cmp("zw.stall", 32'(bus.stall),    32'd0);
    cmp("zw.wb_en", 32'(bus.wb_en),    32'd1);
    step(); idle();
    @(negedge clk); cmp("zw.stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // 3-cycle load: ack on third cycle
    step(); drive_mem(1, 1, 0, 5'd5, 1, 0);
    @(negedge clk);
    cmp("l3.c1.stall", 32'(bus.stall), 32'd1);
    cmp("l3.c1.wb_en", 32'(bus.wb_en), 32'd0);
    step();
    @(negedge clk);
    cmp("l3.c2.stall", 32'(bus.stall),    32'd1);
    cmp("l3.c2.req",   32'(bus.dmem_req), 32'd1);
    cmp("l3.c2.wb_en", 32'(bus.wb_en),    32'd0);
    step(); bus.dmem_ack = 1'b1;
    @(negedge clk);
    cmp("l3.c3.stall", 32'(bus.stall), 32'd0);
    cmp("l3.c3.wb_en", 32'(bus.wb_en), 32'd1);
    step(); idle();
    @(negedge clk); cmp("l3.stall_cnt", 32'(bus.stall_cnt), 32'd2);

    // forwarding
    step(); drive_mem(1, 0, 0, 5'd7, 1, 0); drive_ex(1, 5'd7, 5'd7, 1, 1, 0);
    @(negedge clk);
    cmp("fw.A", 32'(bus.forward_sel_A), 32'd1);
    cmp("fw.B", 32'(bus.forward_sel_B), 32'd1);
    step(); bus.mem_rd = 5'd0; bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0;
    @(negedge clk);
    cmp("fw.r0.A", 32'(bus.forward_sel_A), 32'd0);
    cmp("fw.r0.B", 32'(bus.forward_sel_B), 32'd0);
    step(); bus.mem_rd = 5'd7; bus.ex_rs1 = 5'd7; bus.ex_rs2 = 5'd7; bus.ex_use_rs2 = 1'b0;
    @(negedge clk);
    cmp("fw.nou2.A", 32'(bus.forward_sel_A), 32'd1);
    cmp("fw.nou2.B", 32'(bus.forward_sel_B), 32'd0);

    // taken branch, no stall: two flush cycles
    step(); idle(); drive_ex(1, 5'd0, 5'd0, 0, 0, 1);
    @(negedge clk); cmp("br.c1.flush", 32'(bus.flush), 32'd1);
    step(); idle();
    @(negedge clk); cmp("br.c2.flush", 32'(bus.flush), 32'd1);
    step();
    @(negedge clk);
    cmp("br.c3.flush", 32'(bus.flush),     32'd0);
    cmp("br.flush_cnt", 32'(bus.flush_cnt), 32'd2);

    // branch arriving while the memory access is waiting
    step(); drive_mem(1, 1, 0, 5'd5, 1, 0);
    @(negedge clk); cmp("bs.a.stall", 32'(bus.stall), 32'd1);
    step(); drive_ex(1, 5'd0, 5'd0, 0, 0, 1);
    @(negedge clk);
    cmp("bs.b.stall", 32'(bus.stall), 32'd1);
    cmp("bs.b.flush", 32'(bus.flush), 32'd0);
    step();
    @(negedge clk); cmp("bs.c.flush", 32'(bus.flush), 32'd0);
    step(); bus.dmem_ack = 1'b1;
    @(negedge clk);
    cmp("bs.d.stall", 32'(bus.stall), 32'd0);
    cmp("bs.d.flush", 32'(bus.flush), 32'd1);
    step(); idle();
    @(negedge clk); cmp("bs.e.flush", 32'(bus.flush), 32'd1);
    step();
    @(negedge clk); cmp("bs.f.flush", 32'(bus.flush), 32'd0);

    // timeout: four stalled cycles, then abandon with error
    step(); drive_mem(1, 1, 0, 5'd5, 1, 0);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk); cmp($sformatf("to.c%0d.stall", i), 32'(bus.stall), 32'd1);
      step();
    end
    @(negedge clk);
    cmp("to.c5.stall",   32'(bus.stall),    32'd0);
    cmp("to.c5.wb_en",   32'(bus.wb_en),    32'd0);
    cmp("to.c5.req",     32'(bus.dmem_req), 32'd1);
    cmp("to.c5.mem_err", 32'(bus.mem_err),  32'd0);
    step(); idle();
    @(negedge clk);
    cmp("to.c6.mem_err", 32'(bus.mem_err), 32'd1);
    cmp("to.c6.stall",   32'(bus.stall),   32'd0);
    step();
    @(negedge clk); cmp("to.c7.mem_err", 32'(bus.mem_err), 32'd1);

    // reset asserted mid-wait clears everything at once
    step(); drive_mem(1, 1, 0, 5'd7, 1, 0); drive_ex(1, 5'd7, 5'd7, 1, 1, 1);
    step();
    @(negedge clk); cmp("rw.pre.stall", 32'(bus.stall), 32'd1);
    step(); reset = 1'b0;
    @(negedge clk); all_zero("rw");
    step(); reset = 1'b1; idle();

    // randomized traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      step();
      reset = ($urandom_range(0, 249) != 0);
      drive_mem($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, 5'($urandom_range(0, 7)),
                $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3);
      drive_ex($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 2);
    end
    step(); reset = 1'b1; idle();
    @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
